ssa_window_accumulator: RTL and testbench

//   Downstream consumer of the 4-bit select-chain result stream (the c output of the SSA-transformed mux block).

---
 rtl/ssa_window_accumulator.sv | 114 +++++++++++
 tb/tb_ssa_window_accumulator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ssa_window_accumulator.sv
// Windowed accumulator for the select-chain result stream: a 2-entry input FIFO
// feeds a sum/count FSM whose closed windows are offered on a valid/ready port.
module ssa_window_accumulator #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WINDOW = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [WIDTH-1:0]                       in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   flush,
    output logic [WIDTH+$clog2(WINDOW)-1:0]        out_sum,
    output logic [$clog2(WINDOW):0]                out_count,
    output logic                                   out_valid,
    input  logic                                   out_ready
);
    localparam int unsigned SUM_WIDTH = WIDTH + $clog2(WINDOW);
    localparam int unsigned CNT_WIDTH = $clog2(WINDOW) + 1;
    localparam int unsigned OCC_WIDTH = 2;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     mem [2];
    logic                 wr_ptr, rd_ptr;
    logic [OCC_WIDTH-1:0] occ;
    logic [SUM_WIDTH-1:0] sum, sum_n, sum_inc, out_sum_n;
    logic [CNT_WIDTH-1:0] n, n_n, n_inc, out_count_n;
    logic                 out_valid_n;
    logic                 push, pop;

    // in_ready depends only on registered occupancy, so a same-cycle pop cannot raise it
    assign in_ready = !rst && (occ != OCC_WIDTH'(2));
    assign push     = in_valid && in_ready;
    assign pop      = (state == ACCUM) && (occ != OCC_WIDTH'(0));
    assign sum_inc  = sum + SUM_WIDTH'(mem[rd_ptr]);
    assign n_inc    = n + CNT_WIDTH'(1);

    // FIFO storage needs no reset; occupancy and pointers gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ <= occ + OCC_WIDTH'(push) - OCC_WIDTH'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            sum       <= '0;
            n         <= '0;
            out_sum   <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            sum       <= sum_n;
            n         <= n_n;
            out_sum   <= out_sum_n;
            out_count <= out_count_n;
            out_valid <= out_valid_n;
        end
    end

    // Next-state: accumulate on pop, close on full window or an idle flush, hold until accepted
    always_comb begin
        state_n     = state;
        sum_n       = sum;
        n_n         = n;
        out_sum_n   = out_sum;
        out_count_n = out_count;
        out_valid_n = out_valid;
        case (state)
            ACCUM: begin
                if (pop) begin
                    sum_n = sum_inc;
                    n_n   = n_inc;
                    if (n_inc == CNT_WIDTH'(WINDOW)) begin
                        out_sum_n   = sum_inc;
                        out_count_n = n_inc;
                        out_valid_n = 1'b1;
                        state_n     = HOLD;
                    end
                end else if (flush && (n != '0)) begin
                    out_sum_n   = sum;
                    out_count_n = n;
                    out_valid_n = 1'b1;
                    state_n     = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    sum_n       = '0;
                    n_n         = '0;
                    state_n     = ACCUM;
                end
            end
            default: state_n = ACCUM;
        endcase
    end
endmodule

// File: tb/tb_ssa_window_accumulator.sv
// Scoreboard bench: a sample-level window model predicts each closed window.
module tb_ssa_window_accumulator;
    localparam int unsigned WIDTH  = 4;
    localparam int unsigned WINDOW = 4;
    localparam int unsigned SW     = WIDTH + $clog2(WINDOW);
    localparam int unsigned CW     = $clog2(WINDOW) + 1;

    typedef struct {
        logic [SW-1:0] sum;
        logic [CW-1:0] cnt;
    } result_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [WIDTH-1:0] in_data;
    logic          in_valid, in_ready, flush, out_valid, out_ready;
    logic [SW-1:0] out_sum;
    logic [CW-1:0] out_count;

    result_t exp_q[$];
    int      n_checks = 0, n_pass = 0;
    int      pend_n = 0, pend_sum = 0;
    int      accepted = 0, results = 0, exp_results = 0;
    logic    flush_expect = 1'b0;

    ssa_window_accumulator #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_sum(out_sum),
        .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic void close_window();
        result_t r;
        r.sum = SW'(pend_sum);
        r.cnt = CW'(pend_n);
        exp_q.push_back(r);
        exp_results++;
        pend_n   = 0;
        pend_sum = 0;
    endfunction

    // Monitor and model, sampled mid-cycle so the upcoming edge's handshakes are known
    always @(negedge clk) begin
        if (rst) begin
            check("rst_in_ready", 32'(in_ready), 0);
            pend_n   = 0;
            pend_sum = 0;
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 0);
                end else begin
                    check("out_sum", 32'(out_sum), 32'(exp_q[0].sum));
                    check("out_count", 32'(out_count), 32'(exp_q[0].cnt));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        results++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                accepted++;
                pend_sum += int'(in_data);
                pend_n++;
                if (pend_n == WINDOW) close_window();
            end
            if (flush && flush_expect && pend_n > 0) close_window();
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        int  t = 0;
        logic acc;
        in_data  = WIDTH'(v);
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 50);
        if (!acc) check("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        flush_expect = 1'b1;
        tick(1);
        flush = 1'b0;
        flush_expect = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            tick(1);
            t++;
        end
        check("drain_timeout", 32'(t < 200), 1);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick(2);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_out_count", 32'(out_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);

        // 1: basic window
        for (int i = 1; i <= 4; i++) push(i);
        drain();

        // 2: max values, no wrap
        for (int i = 0; i < 4; i++) push(15);
        drain();

        // 3: back-pressure fills the FIFO behind a held result
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 1; i <= 6; i++) push(i);
        tick(4);
        @(negedge clk);
        check("hold_in_ready", 32'(in_ready), 0);
        check("hold_accepted", 32'(accepted), 6);
        check("hold_out_valid", 32'(out_valid), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 7; i <= 10; i++) push(i);
        tick(8);
        pulse_flush();
        drain();

        // 4: partial window closed by flush, next starts from zero
        push(5); push(7);
        tick(3);
        pulse_flush();
        drain();
        for (int i = 0; i < 4; i++) push(1);
        drain();

        // 5: reset aborts a partial window
        for (int i = 0; i < 3; i++) push(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) push(1);
        drain();

        // 6a: flush with empty window is ignored
        tick(2);
        pulse_flush();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_flush_valid", 32'(out_valid), 0);
        end
        @(posedge clk); #1;

        // 6b: flush coinciding with a pop is ignored
        push(2); push(3);
        flush = 1'b1;
        push(4);
        flush = 1'b0;
        push(6);
        drain();

        tick(3);
        check("queue_empty", 32'(exp_q.size()), 0);
        check("result_count", 32'(results), 32'(exp_results));
        check("expected_results", 32'(exp_results), 9);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
